// File: rtl/frontend_pkg.sv
// Shared frontend definitions: time-tag codes, period width and the
// output-mux FSM state encoding used by timetag_arbiter.
package frontend_pkg;

  localparam int unsigned PERIOD_W = 48;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CODE_W   = 8;
  localparam int unsigned HALF_W   = PERIOD_W / 2;

  localparam logic [CODE_W-1:0] TAG_HI_CODE = 8'hF0;
  localparam logic [CODE_W-1:0] TAG_LO_CODE = 8'hF1;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    TAG_HI = 2'd1,
    TAG_LO = 2'd2
  } state_e;

endpackage

// File: rtl/timetag_arbiter_if.sv
// Bus bundle between the frontend (master: timer + channels + link sink)
// and timetag_arbiter (slave).
//   period_done/period : timer rollover pulse and its 48-bit count
//   in_valid/in_data   : per-requester words, requester i at [32i+31:32i]
//   in_ready           : one-hot accept strobe back to the requesters
//   out_valid/out_data : merged output stream, out_ready from downstream
//   tag_drop           : saturating dropped-tag counter
interface timetag_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
);
  import frontend_pkg::*;

  logic                    period_done;
  logic [PERIOD_W-1:0]     period;
  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        in_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [15:0]             tag_drop;

  modport master (
    output period_done, period, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, tag_drop
  );

  modport slave (
    input  period_done, period, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, tag_drop
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin requester picker.
//   clk, rst  : clock, async active-high reset
//   req_i     : request vector
//   adv_i     : a grant is taken this cycle; move pointer past the winner
//   gnt_o     : one-hot grant (combinational)
//   gnt_idx_o : index of the granted requester (combinational)
//   any_o     : at least one request present (combinational)
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // First request at or after the pointer, wrapping.
  always_comb begin
    int unsigned j;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(ptr_q) + k) % N_REQ;
      if (!any_o && req_i[IDX_W'(j)]) begin
        any_o               = 1'b1;
        gnt_o[IDX_W'(j)]    = 1'b1;
        gnt_idx_o           = IDX_W'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && any_o) begin
      ptr_d = IDX_W'((32'(gnt_idx_o) + 32'd1) % N_REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/timetag_arbiter.sv
// Merges N_REQ data-word streams with two-word time tags into one output
// stream. Tags take priority over data and are never split; data is shared
// round-robin.
//   clk, rst : clock, async active-high reset
//   bus      : timetag_arbiter_if slave (period capture, requester inputs,
//              in_ready strobes, registered output word, tag_drop counter)
module timetag_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 32,
  parameter logic [7:0]  TAG_HI_CODE = frontend_pkg::TAG_HI_CODE,
  parameter logic [7:0]  TAG_LO_CODE = frontend_pkg::TAG_LO_CODE
) (
  input  logic clk,
  input  logic rst,
  timetag_arbiter_if.slave bus
);
  import frontend_pkg::*;

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q;
  logic                tag_pend_q;
  logic [PERIOD_W-1:0] tag_reg_q;
  logic [HALF_W-1:0]   tag_lo_q;
  logic [15:0]         tag_drop_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;

  logic                free;
  logic                act_data;
  logic                take_tag;
  logic                grant_en;
  logic [N_REQ-1:0]    gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                any_req;
  logic [DATA_W-1:0]   gnt_word;

  // DATA and TAG_LO behave identically once the output slot is free.
  assign free     = !out_valid_q || bus.out_ready;
  assign act_data = free && (state_q != TAG_HI);
  assign take_tag = act_data && tag_pend_q;
  assign grant_en = act_data && !tag_pend_q && any_req;
  assign gnt_word = bus.in_data[gnt_idx*DATA_W +: DATA_W];

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.in_valid),
    .adv_i     (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  // Accept strobe is forced low while reset is held.
  assign bus.in_ready  = (grant_en && !rst) ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.tag_drop  = tag_drop_q;

  // Tag capture, output FSM and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DATA;
      tag_pend_q  <= 1'b0;
      tag_reg_q   <= '0;
      tag_lo_q    <= '0;
      tag_drop_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // A capture coinciding with the pending tag being launched is kept.
      if (bus.period_done) begin
        if (tag_pend_q && !take_tag) begin
          if (tag_drop_q != 16'hFFFF) tag_drop_q <= tag_drop_q + 16'd1;
        end else begin
          tag_reg_q  <= bus.period;
          tag_pend_q <= 1'b1;
        end
      end else if (take_tag) begin
        tag_pend_q <= 1'b0;
      end

      case (state_q)
        TAG_HI: begin
          if (free) begin
            out_data_q  <= {TAG_LO_CODE, tag_lo_q};
            out_valid_q <= 1'b1;
            state_q     <= TAG_LO;
          end
        end
        default: begin
          if (free) begin
            if (tag_pend_q) begin
              out_data_q  <= {TAG_HI_CODE, tag_reg_q[PERIOD_W-1:HALF_W]};
              // Snapshot low half so a same-cycle capture can't alter it.
              tag_lo_q    <= tag_reg_q[HALF_W-1:0];
              out_valid_q <= 1'b1;
              state_q     <= TAG_HI;
            end else if (any_req) begin
              out_data_q  <= gnt_word;
              out_valid_q <= 1'b1;
              state_q     <= DATA;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= DATA;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timetag_arbiter.sv
// Directed, table-driven bench for timetag_arbiter.
module tb_timetag_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  timetag_arbiter_if #(.N_REQ(4), .DATA_W(32)) bus ();

  timetag_arbiter #(.N_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        pd;
    logic [47:0] per;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  x_rdy;
    logic        x_ov;
    logic [31:0] x_od;
    logic [15:0] x_drop;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic pd, input logic [47:0] per, input logic [3:0] iv,
                     input logic ordy, input logic [3:0] x_rdy, input logic x_ov,
                     input logic [31:0] x_od, input logic [15:0] x_drop);
    vec_t v;
    v.pd = pd; v.per = per; v.iv = iv; v.ordy = ordy;
    v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_od = x_od; v.x_drop = x_drop;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  initial begin
    rst = 1'b1;
    bus.period_done = 1'b0;
    bus.period      = '0;
    bus.in_valid    = '0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < 4; i++) bus.in_data[i*32 +: 32] = w(i);

    // Single tag, idle inputs
    add(1, 48'h0000_0ABC_DEF1, 4'h0, 1, 4'h0, 0, 32'h0, 16'd0);
    add(0, 48'h0, 4'h0, 1, 4'h0, 1, 32'hF000_000A, 16'd0);
    add(0, 48'h0, 4'h0, 1, 4'h0, 1, 32'hF1BC_DEF1, 16'd0);
    add(0, 48'h0, 4'h0, 1, 4'h0, 0, 32'h0, 16'd0);
    // Round-robin fairness
    for (int i = 0; i < 8; i++)
      add(0, 48'h0, 4'hF, 1, 4'(1 << (i % 4)), 1, w(i % 4), 16'd0);
    // Tag preempts data, pair unsplit, RR resumes
    add(1, 48'h1234_5678_9ABC, 4'hF, 1, 4'h1, 1, w(0), 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h0, 1, 32'hF012_3456, 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h0, 1, 32'hF178_9ABC, 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h2, 1, w(1), 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h4, 1, w(2), 16'd0);
    // Backpressure during TAG_HI
    add(1, 48'hABCD_EF00_0001, 4'hF, 1, 4'h8, 1, w(3), 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h0, 1, 32'hF0AB_CDEF, 16'd0);
    for (int i = 0; i < 5; i++)
      add(0, 48'h0, 4'hF, 0, 4'h0, 1, 32'hF0AB_CDEF, 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h0, 1, 32'hF100_0001, 16'd0);
    add(0, 48'h0, 4'hF, 1, 4'h1, 1, w(0), 16'd0);
    // Overflow, then capture on launch cycle and back-to-back tags
    add(1, 48'd5, 4'h0, 0, 4'h0, 1, w(0), 16'd0);
    add(1, 48'd6, 4'h0, 0, 4'h0, 1, w(0), 16'd1);
    add(0, 48'h0, 4'h0, 0, 4'h0, 1, w(0), 16'd1);
    add(1, 48'd7, 4'h0, 1, 4'h0, 1, 32'hF000_0000, 16'd1);
    add(0, 48'h0, 4'h0, 1, 4'h0, 1, 32'hF100_0005, 16'd1);
    add(0, 48'h0, 4'h0, 1, 4'h0, 1, 32'hF000_0000, 16'd1);
    add(0, 48'h0, 4'h0, 1, 4'h0, 1, 32'hF100_0007, 16'd1);
    add(0, 48'h0, 4'h0, 1, 4'h0, 0, 32'h0, 16'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_tag_drop", 32'(bus.tag_drop), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      bus.period_done = vq[i].pd;
      bus.period      = vq[i].per;
      bus.in_valid    = vq[i].iv;
      bus.out_ready   = vq[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vq[i].x_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vq[i].x_ov));
      if (vq[i].x_ov) chk($sformatf("v%0d_out_data", i), bus.out_data, vq[i].x_od);
      chk($sformatf("v%0d_tag_drop", i), 32'(bus.tag_drop), 32'(vq[i].x_drop));
    end

    // Async reset between TAG_HI and TAG_LO
    @(negedge clk);
    bus.period_done = 1'b1;
    bus.period      = 48'h0000_7700_0088;
    bus.in_valid    = 4'h0;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    bus.period_done = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_tag_hi", bus.out_data, 32'hF000_0077);
    @(negedge clk);
    bus.in_valid = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_out_data", bus.out_data, 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd0);
    chk("ar_tag_drop", 32'(bus.tag_drop), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_rel_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("ar_rel_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ar_rel_out_data", bus.out_data, w(0));
    @(negedge clk);
    bus.in_valid = 4'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
